buffered_ram_stream_reader: RTL and testbench

// - Read-side client for the dual-port buffered RAM (registered address + registered q, 2-cycle read latency).
// - Walks a programmed address window and drives the RAM read address.
// - Re-times returned words into a valid/ready stream that tolerates backpressure, for the MIPI TX packetiser.
// - Write side of the RAM stays with the USB ingress logic; this block never writes.

---
 rtl/buffered_ram_stream_reader_pkg.sv | 16 +
 rtl/buffered_ram_stream_reader_if.sv | 27 ++
 rtl/buffered_ram_stream_reader_skid_fifo.sv | 63 ++++++
 rtl/buffered_ram_stream_reader.sv | 105 ++++++++++
 tb/tb_buffered_ram_stream_reader.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/buffered_ram_stream_reader_pkg.sv
// Shared constants and FSM state type for the buffered-RAM stream reader.
package buffered_ram_stream_reader_pkg;

  localparam int RD_LATENCY = 2;
  localparam int SKID_DEPTH = 4;
  localparam int SKID_PTR_W = $clog2(SKID_DEPTH);
  localparam int SKID_CNT_W = $clog2(SKID_DEPTH + 1);
  localparam int INFLIGHT_W = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

endpackage

// File: rtl/buffered_ram_stream_reader_if.sv
// Control, RAM read port and output stream of the reader; slave is the reader side.
interface buffered_ram_stream_reader_if #(
  parameter int p_addresswidth = 4,
  parameter int p_datawidth    = 16,
  parameter int p_lenwidth     = p_addresswidth + 1
);
  logic                      in_start;
  logic [p_addresswidth-1:0] in_startaddr;
  logic [p_lenwidth-1:0]     in_length;
  logic [p_addresswidth-1:0] out_rdaddress;
  logic [p_datawidth-1:0]    in_rddata;
  logic                      out_valid;
  logic [p_datawidth-1:0]    out_data;
  logic                      in_ready;
  logic                      out_busy;
  logic                      out_done;

  modport master (
    output in_start, in_startaddr, in_length, in_rddata, in_ready,
    input  out_rdaddress, out_valid, out_data, out_busy, out_done
  );

  modport slave (
    input  in_start, in_startaddr, in_length, in_rddata, in_ready,
    output out_rdaddress, out_valid, out_data, out_busy, out_done
  );
endinterface

// File: rtl/buffered_ram_stream_reader_skid_fifo.sv
// Small skid FIFO absorbing RAM words still in flight when the stream stalls.
module ram_reader_skid_fifo
  import buffered_ram_stream_reader_pkg::*;
#(
  parameter int p_width = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [p_width-1:0]    push_data,
  input  logic                  pop,
  output logic                  valid,
  output logic [p_width-1:0]    data,
  output logic [SKID_CNT_W-1:0] count
);

  logic [p_width-1:0]    mem_q [SKID_DEPTH];
  logic [p_width-1:0]    mem_d [SKID_DEPTH];
  logic [SKID_PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [SKID_CNT_W-1:0] count_q, count_d;
  logic                  do_push, do_pop;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    do_pop   = pop && (count_q != '0);
    do_push  = push && ((count_q != SKID_CNT_W'(SKID_DEPTH)) || do_pop);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + SKID_PTR_W'(1);
    end
    if (do_pop) rd_ptr_d = rd_ptr_q + SKID_PTR_W'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + SKID_CNT_W'(1);
      2'b01:   count_d = count_q - SKID_CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the storage is cleared on reset so out_data reads 0 afterwards; it is only 4 words.
      for (int i = 0; i < SKID_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign valid = (count_q != '0);
  assign data  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/buffered_ram_stream_reader.sv
// Walks an address window of the buffered RAM and re-times the returned words
// into a backpressure-tolerant valid/ready stream.
module buffered_ram_stream_reader
  import buffered_ram_stream_reader_pkg::*;
#(
  parameter int p_addresswidth = 4,
  parameter int p_datawidth    = 16,
  parameter int p_lenwidth     = p_addresswidth + 1
) (
  input logic inclk,
  input logic inrst,
  buffered_ram_stream_reader_if.slave bus
);

  state_e                    state_q, state_d;
  logic [p_addresswidth-1:0] addr_q, addr_d;
  logic [p_lenwidth-1:0]     rem_q, rem_d;
  logic [RD_LATENCY-1:0]     lat_q, lat_d;
  logic                      done_q, done_d;

  logic [SKID_CNT_W-1:0]     fifo_count;
  logic [INFLIGHT_W-1:0]     inflight;
  logic                      fifo_valid, pop, issue, credit_ok;
  logic [p_datawidth-1:0]    fifo_data;

  // Words issued but not yet in the FIFO plus words in the FIFO may never exceed its depth.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LATENCY; i++) inflight = inflight + INFLIGHT_W'(lat_q[i]);
    credit_ok = (fifo_count + SKID_CNT_W'(inflight)) < SKID_CNT_W'(SKID_DEPTH);
    pop       = fifo_valid && bus.in_ready;
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    done_d  = 1'b0;
    issue   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.in_start) begin
          if (bus.in_length != '0) begin
            state_d = ST_ISSUE;
            addr_d  = bus.in_startaddr;
            rem_d   = bus.in_length;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      ST_ISSUE: begin
        if (credit_ok) begin
          issue  = 1'b1;
          addr_d = addr_q + p_addresswidth'(1);
          rem_d  = rem_q - p_lenwidth'(1);
          if (rem_q == p_lenwidth'(1)) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // Everything is issued, so a lone FIFO word with nothing in flight is the last one.
        if (inflight == '0 && fifo_count == SKID_CNT_W'(1) && pop) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    lat_d = {lat_q[RD_LATENCY-2:0], issue};
  end

  always_ff @(posedge inclk) begin
    if (inrst) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      lat_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      lat_q   <= lat_d;
      done_q  <= done_d;
    end
  end

  ram_reader_skid_fifo #(.p_width(p_datawidth)) u_skid_fifo (
    .clk       (inclk),
    .rst       (inrst),
    .push      (lat_q[RD_LATENCY-1]),
    .push_data (bus.in_rddata),
    .pop       (pop),
    .valid     (fifo_valid),
    .data      (fifo_data),
    .count     (fifo_count)
  );

  assign bus.out_rdaddress = addr_q;
  assign bus.out_valid     = fifo_valid;
  assign bus.out_data      = fifo_data;
  assign bus.out_busy      = (state_q != ST_IDLE);
  assign bus.out_done      = done_q;

endmodule

// File: tb/tb_buffered_ram_stream_reader.sv
// Bench for buffered_ram_stream_reader: behavioural RAM, transaction-level model
// compared every cycle, plus directed literal expectations.
module tb_buffered_ram_stream_reader;

  localparam int AW = 4;
  localparam int DW = 16;
  localparam int LW = AW + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  buffered_ram_stream_reader_if #(.p_addresswidth(AW), .p_datawidth(DW), .p_lenwidth(LW)) bus ();

  buffered_ram_stream_reader #(.p_addresswidth(AW), .p_datawidth(DW), .p_lenwidth(LW)) dut (
    .inclk (clk),
    .inrst (rst),
    .bus   (bus)
  );

  // Dual-port RAM read side: registered address, registered q.
  logic [DW-1:0] ram [2**AW];
  logic [AW-1:0] ram_addr_q;
  logic [DW-1:0] ram_q;
  initial for (int i = 0; i < 2**AW; i++) ram[i] = 16'hA000 + DW'(i);
  always @(posedge clk) begin
    ram_addr_q <= bus.out_rdaddress;
    ram_q      <= ram[ram_addr_q];
  end
  assign bus.in_rddata = ram_q;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit chk_en = 1'b0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Transaction-level model: counts of words issued/accepted and the credit rule.
  bit          m_busy = 1'b0;
  bit          m_done = 1'b0;
  int          m_len, m_issued, m_accepted;
  logic [AW-1:0] m_start = '0;
  logic [AW-1:0] m_addr  = '0;
  int          issue_cyc [0:31];

  always @(negedge clk) begin
    if (chk_en) begin
      bit          exp_valid, issue, done_n;
      logic [AW-1:0] head;
      exp_valid = m_busy && (m_accepted < m_issued) && (issue_cyc[m_accepted] + 3 <= cyc);
      head      = m_start + AW'(m_accepted);
      check("m_valid", 32'(bus.out_valid), 32'(exp_valid));
      check("m_busy", 32'(bus.out_busy), 32'(m_busy));
      check("m_done", 32'(bus.out_done), 32'(m_done));
      check("m_rdaddress", 32'(bus.out_rdaddress), 32'(m_addr));
      if (exp_valid) check("m_data", 32'(bus.out_data), 32'(16'hA000 + DW'(head)));

      if (rst) begin
        m_busy = 1'b0; m_done = 1'b0; m_addr = '0;
        m_issued = 0; m_accepted = 0; m_len = 0;
      end else begin
        done_n = 1'b0;
        if (m_busy) begin
          issue = (m_issued < m_len) && ((m_issued - m_accepted) < 4);
          if (issue) begin
            issue_cyc[m_issued] = cyc;
            m_issued++;
            m_addr = m_addr + AW'(1);
          end
          if (exp_valid && bus.in_ready) begin
            m_accepted++;
            if (m_accepted == m_len) begin
              m_busy = 1'b0;
              done_n = 1'b1;
            end
          end
        end else if (bus.in_start) begin
          if (bus.in_length == '0) done_n = 1'b1;
          else begin
            m_busy = 1'b1; m_start = bus.in_startaddr; m_addr = bus.in_startaddr;
            m_len = int'(bus.in_length); m_issued = 0; m_accepted = 0;
          end
        end
        m_done = done_n;
      end
    end
  end

  // Leaves the bench in cycle 1 of the burst (the cycle after in_start is sampled).
  task automatic pulse_start(input logic [AW-1:0] a, input logic [LW-1:0] l);
    bus.in_start     = 1'b1;
    bus.in_startaddr = a;
    bus.in_length    = l;
    tick();
    bus.in_start = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    int  acc;
    bit  seen_done, finished;
    bus.in_start = 1'b0; bus.in_startaddr = '0; bus.in_length = '0; bus.in_ready = 1'b1;
    rst = 1'b1;
    idle(3);
    chk_en = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_rdaddress", 32'(bus.out_rdaddress), 32'd0);
    check("rst_valid", 32'(bus.out_valid), 32'd0);
    check("rst_data", 32'(bus.out_data), 32'd0);
    check("rst_busy", 32'(bus.out_busy), 32'd0);
    check("rst_done", 32'(bus.out_done), 32'd0);
    idle(2);

    // Basic burst: addresses 5..12, data A005..A00C in cycles 4..11, done in 12.
    pulse_start(4'd5, 5'd8);
    for (int k = 1; k <= 12; k++) begin
      if (k <= 8) check("t1_addr", 32'(bus.out_rdaddress), 32'(5 + k - 1));
      check("t1_valid", 32'(bus.out_valid), 32'(k >= 4 && k <= 11));
      if (k >= 4 && k <= 11) check("t1_data", 32'(bus.out_data), 32'(16'hA005 + k - 4));
      check("t1_done", 32'(bus.out_done), 32'(k == 12));
      if (k < 12) tick();
    end
    idle(3);

    // Address wrap.
    pulse_start(4'd14, 5'd4);
    for (int k = 1; k <= 8; k++) begin
      if (k <= 4) check("t2_addr", 32'(bus.out_rdaddress), 32'((14 + k - 1) % 16));
      if (k >= 4 && k <= 7) check("t2_data", 32'(bus.out_data), 32'(16'hA000 + (14 + k - 4) % 16));
      check("t2_done", 32'(bus.out_done), 32'(k == 8));
      tick();
    end
    idle(2);

    // Backpressure: in_ready low in cycles 6..12.
    acc = 0; seen_done = 1'b0;
    pulse_start(4'd0, 5'd16);
    for (int k = 1; k <= 60 && !seen_done; k++) begin
      bus.in_ready = !(k >= 6 && k <= 12);
      if (k >= 7 && k <= 12) check("t3_addr_hold", 32'(bus.out_rdaddress), 32'd6);
      if (bus.out_valid && bus.in_ready) begin
        check("t3_order", 32'(bus.out_data), 32'(16'hA000 + acc));
        acc++;
      end
      if (bus.out_done) seen_done = 1'b1;
      tick();
    end
    bus.in_ready = 1'b1;
    check("t3_count", 32'(acc), 32'd16);
    check("t3_done_seen", 32'(seen_done), 32'd1);
    idle(2);

    // Zero-length burst.
    pulse_start(4'd7, 5'd0);
    check("t4_done", 32'(bus.out_done), 32'd1);
    check("t4_busy", 32'(bus.out_busy), 32'd0);
    tick();
    check("t4_done_pulse", 32'(bus.out_done), 32'd0);
    check("t4_valid", 32'(bus.out_valid), 32'd0);
    idle(2);

    // Second in_start mid-burst is ignored.
    pulse_start(4'd2, 5'd6);
    for (int k = 1; k <= 10; k++) begin
      bus.in_start = (k == 3);
      bus.in_startaddr = 4'd9;
      bus.in_length = 5'd3;
      if (k == 5) check("t5_addr", 32'(bus.out_rdaddress), 32'd6);
      if (k >= 4 && k <= 9) check("t5_data", 32'(bus.out_data), 32'(16'hA002 + k - 4));
      check("t5_done", 32'(bus.out_done), 32'(k == 10));
      if (k < 10) tick();
    end
    bus.in_start = 1'b0;
    idle(3);

    // Reset mid-burst, then a fresh burst from address 3.
    pulse_start(4'd0, 5'd10);
    idle(4);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t6_rdaddress", 32'(bus.out_rdaddress), 32'd0);
    check("t6_valid", 32'(bus.out_valid), 32'd0);
    check("t6_data", 32'(bus.out_data), 32'd0);
    check("t6_busy", 32'(bus.out_busy), 32'd0);
    check("t6_done", 32'(bus.out_done), 32'd0);
    pulse_start(4'd3, 5'd2);
    for (int k = 1; k <= 6; k++) begin
      if (k == 4 || k == 5) check("t6_data_new", 32'(bus.out_data), 32'(16'hA003 + k - 4));
      check("t6_done_new", 32'(bus.out_done), 32'(k == 6));
      if (k < 6) tick();
    end
    idle(2);

    // Randomized bursts with random backpressure, stray starts and rare resets.
    for (int b = 0; b < 40; b++) begin
      pulse_start(AW'($urandom_range(0, 15)), LW'($urandom_range(0, 16)));
      finished = 1'b0;
      for (int k = 0; k < 300; k++) begin
        bus.in_start = 1'b0;
        rst = 1'b0;
        bus.in_ready = ($urandom_range(0, 3) != 0);
        if (!bus.out_busy && !bus.out_valid) begin
          finished = 1'b1;
          break;
        end
        if (bus.out_busy && $urandom_range(0, 39) == 0) begin
          bus.in_start = 1'b1;
          bus.in_startaddr = AW'($urandom_range(0, 15));
          bus.in_length = LW'($urandom_range(1, 16));
        end
        if ($urandom_range(0, 399) == 0) rst = 1'b1;
        tick();
      end
      check("rand_done_in_budget", 32'(finished), 32'd1);
      bus.in_start = 1'b0;
      rst = 1'b0;
      bus.in_ready = 1'b1;
      idle($urandom_range(1, 3));
    end

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
